// File: rtl/ysyx_25030081_mem_pkg.sv
// Shared definitions for the core's load/store memory port: responder FSM
// state encoding, response error codes and the byte-lane count.
package ysyx_25030081_mem_pkg;

    // Byte lanes per 32-bit word; the core-side initiator sizes its mask from this.
    localparam int LANES = 4;

    // Response error codes carried on resp_err.
    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ysyx_25030081_sram_array.sv
// Single-port word array with per-byte write enables and a registered read
// port. Contents are never reset; rdata holds its value while en is low.
module ysyx_25030081_sram_array
    import ysyx_25030081_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [LANES-1:0] wmask,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // One access per enabled cycle: masked lane write, or registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wmask[l]) begin
                        mem[idx][8*l +: 8] <= wdata[8*l +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/ysyx_25030081_sram_slave.sv
// Memory-side responder for the core's load/store port. Accepts one request,
// waits a fixed LATENCY, performs the access on its private word array and
// returns read data or a write acknowledgement. Accesses outside
// [BASE, BASE+DEPTH*4) touch nothing and return resp_err=1 with zero data.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The initiator keeps req_* stable while req_valid is high and not
// yet accepted; this block holds resp_valid/resp_rdata/resp_err stable until
// resp_ready is seen. req_ready and resp_valid are registered state decodes
// with no combinational path from any input.
module ysyx_25030081_sram_slave
    import ysyx_25030081_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LANES-1:0]      req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            dbg_state
);

    localparam int                    IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WINDOW   = ADDR_WIDTH'(DEPTH * 4);
    localparam logic [3:0]            CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic                    wen_q;
    logic                    err_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [LANES-1:0]        wmask_q;
    logic                    rd_sel;

    logic [ADDR_WIDTH-1:0]   offset;
    logic                    in_range;
    logic                    arr_en;
    logic [DATA_WIDTH-1:0]   arr_rdata;

    // Unsigned wrap makes addresses below BASE land far above WINDOW, so one
    // compare covers both ends of the window.
    assign offset   = req_addr - BASE;
    assign in_range = offset < WINDOW;

    // Access fires on the WAIT->RESP edge; a reset on that same edge cancels it.
    assign arr_en = (state == ST_WAIT) && (cnt == 4'd0) && !err_q && !rst;

    // Read data is only presented for successful reads; writes and errors return 0.
    assign resp_rdata = rd_sel ? arr_rdata : '0;
    assign dbg_state  = state;

    ysyx_25030081_sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (wen_q),
        .wmask (wmask_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Request/latency/response sequencing with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= RESP_OK;
            rd_sel     <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q     <= req_wen;
                        err_q     <= !in_range;
                        idx_q     <= offset[IDX_W+1:2];
                        wdata_q   <= req_wdata;
                        wmask_q   <= req_wmask;
                        cnt       <= CNT_LOAD;
                        req_ready <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= err_q ? RESP_ERR : RESP_OK;
                        rd_sel     <= !wen_q && !err_q;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= RESP_OK;
                        rd_sel     <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030081_sram_slave.sv
// Bench for the SRAM responder: table of request vectors with a response
// scoreboard, plus sequences for back-pressure, reset in WAIT and
// back-to-back spacing on a LATENCY=1 instance.
module tb_ysyx_25030081_sram_slave;

    localparam int L0 = 2;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (LATENCY = 2) ----------------
    logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    ysyx_25030081_sram_slave #(.LATENCY(L0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    // ---------------- DUT 1 (LATENCY = 1, resp_ready tied high) ----------------
    logic        req_valid1 = 1'b0, req_wen1 = 1'b1;
    logic [31:0] req_addr1 = 32'h8000_0040, req_wdata1 = 32'h0;
    logic [3:0]  req_wmask1 = 4'hF;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;
    logic [1:0]  dbg_state1;

    ysyx_25030081_sram_slave #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wmask(req_wmask1),
        .resp_valid(resp_valid1), .resp_ready(1'b1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .dbg_state(dbg_state1)
    );

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];   // {err, rdata}
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string name);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, {31'd0, resp_err, resp_rdata}, {31'd0, e});
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [31:0] exp_rdata,
                          input logic exp_err, input string name);
        int wait_n;
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        exp_q.push_back({exp_err, exp_rdata});
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!req_ready) begin
            check({name, "_accept_timeout"}, 64'd0, 64'd1);
            req_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk);   // acceptance edge T0
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!resp_valid && lat < 20);
        check({name, "_latency"}, 64'(lat), 64'(L0));
        check_resp(name);
        @(posedge clk);   // response handshake edge
        #1 check({name, "_idle_after"}, {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    vec_t vecs[14];
    int   acc[$];

    initial begin
        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0014, 32'h1122_3344, 4'hF,    32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0014, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h8000_0014, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF,    32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0,    32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF,    32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0,    32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h8000_0014, 32'hFFFF_FFFF, 4'h0,    32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h8000_0014, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0};
        vecs[11] = '{1'b1, 32'h8000_0FFC, 32'h5A5A_5A5A, 4'hF,    32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0,    32'h5A5A_5A5A, 1'b0};
        vecs[13] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0};

        // Reset and reset-state checks
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err",   64'(resp_err),   64'd0);
        check("rst_state",      64'(dbg_state),  64'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Random full-word write/read pairs on words the table does not touch
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, d;
            a = 32'h8000_0000 + 32'((64 + i * 8 + $urandom_range(0, 7)) * 4);
            d = $urandom;
            do_req(1'b1, a, d, 4'hF, 32'h0, 1'b0, $sformatf("rnd_w%0d", i));
            do_req(1'b0, a, 32'h0, 4'h0, d, 1'b0, $sformatf("rnd_r%0d", i));
        end

        // Back-pressure: response held with resp_ready low while req_valid toggles
        begin
            int lat;
            @(negedge clk);
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            req_wen    = 1'b0;
            req_addr   = 32'h8000_0010;
            exp_q.push_back({1'b0, 32'hDEAD_BEEF});
            @(posedge clk);
            #1 req_valid = 1'b0;
            lat = 0;
            do begin
                @(posedge clk);
                #1 lat++;
            end while (!resp_valid && lat < 20);
            check("bp_latency", 64'(lat), 64'(L0));
            check_resp("bp_first");
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                req_valid = ~req_valid;
                req_wen   = 1'b1;
                req_wdata = 32'h0;
                req_wmask = 4'hF;
                check($sformatf("bp_hold%0d", k),
                      {29'd0, resp_valid, resp_err, req_ready, resp_rdata},
                      {29'd0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF});
            end
            @(negedge clk);
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk);
            #1 check("bp_release", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
            do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "bp_after");
        end

        // Reset on the commit edge of a write: the write must not land
        do_req(1'b1, 32'h8000_0020, 32'h0000_0001, 4'hF, 32'h0, 1'b0, "rw_pre");
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'hFFFF_FFFF;
        req_wmask = 4'hF;
        @(posedge clk);               // T0
        #1 req_valid = 1'b0;
        @(posedge clk);               // T0+1, still in WAIT
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);               // T0+2, would have committed
        #1 check("rw_after_rst", {61'd0, req_ready, resp_valid, resp_err},
                 {61'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h0000_0001, 1'b0, "rw_read");

        // LATENCY=1 back-to-back acceptances are 3 cycles apart
        @(negedge clk);
        req_valid1 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (req_ready1) acc.push_back(k);
            req_wdata1 = $urandom;
            @(negedge clk);
        end
        req_valid1 = 1'b0;
        check("b2b_count", 64'(acc.size()), 64'd5);
        for (int k = 1; k < acc.size(); k++) begin
            check($sformatf("b2b_gap%0d", k), 64'(acc[k] - acc[k-1]), 64'd3);
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
